// File: rtl/pc_fetch_sequencer.sv
// Fetch/execute sequencer: fetches an instruction at pc, holds it for decode
// until the stage completes, then branches, halts on HALT_INSTR or halts on a misaligned target.
//
// state | meaning
// IDLE  | out of reset, pc parked at RESET_PC, waiting for start
// FETCH | imem_req high, waiting for imem_ack
// EXEC  | instr presented with instr_valid, waiting for stage_done
// HALT  | halted; pc/instr/retired frozen until start
module pc_fetch_sequencer #(
  parameter logic [7:0]  RESET_PC    = 8'd0,
  parameter logic [31:0] HALT_INSTR  = 32'h00000073,
  // Ceiling for the retired counter; lowered only when a shorter saturation point is wanted.
  parameter logic [15:0] RETIRED_SAT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  next_pc,
  input  logic        stage_done,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  output logic [7:0]  pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [15:0] retired,
  output logic        halted,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      imem_req     <= 1'b0;
      instr        <= 32'h0;
      instr_valid  <= 1'b0;
      retired      <= 16'h0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pc       <= RESET_PC;
            imem_req <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (stage_done) begin
            instr_valid <= 1'b0;
            if (retired < RETIRED_SAT) begin
              retired <= retired + 16'd1;
            end
            // A misaligned target wins over the halt instruction.
            if (next_pc[1:0] != 2'b00) begin
              halted       <= 1'b1;
              misalign_err <= 1'b1;
              state        <= HALT;
            end else if (instr == HALT_INSTR) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              pc       <= next_pc;
              imem_req <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        HALT: begin
          if (start) begin
            pc           <= RESET_PC;
            retired      <= 16'h0;
            misalign_err <= 1'b0;
            halted       <= 1'b0;
            instr_valid  <= 1'b0;
            imem_req     <= 1'b1;
            state        <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign imem_addr = pc;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios followed by random programs,
// checked every cycle against a transaction-level model of the sequencer rules.
module tb_pc_fetch_sequencer;

  localparam logic [7:0]  RST_PC    = 8'h00;
  localparam logic [31:0] HALT_I    = 32'h00000073;
  localparam logic [31:0] NOP_I     = 32'h00000013;
  localparam int unsigned SAT_SMALL = 48;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  next_pc;
  logic        stage_done;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        imem_req, instr_valid, halted, misalign_err;
  logic [7:0]  imem_addr, pc;
  logic [31:0] instr;
  logic [15:0] retired;

  logic        s_imem_req, s_instr_valid, s_halted, s_misalign_err;
  logic [7:0]  s_imem_addr, s_pc;
  logic [31:0] s_instr;
  logic [15:0] s_retired;

  pc_fetch_sequencer #(.RESET_PC(RST_PC), .HALT_INSTR(HALT_I)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .next_pc(next_pc),
    .stage_done(stage_done), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc), .instr(instr),
    .instr_valid(instr_valid), .retired(retired), .halted(halted),
    .misalign_err(misalign_err)
  );

  // Same stimulus, lower counter ceiling so saturation is reachable quickly.
  pc_fetch_sequencer #(.RESET_PC(RST_PC), .HALT_INSTR(HALT_I),
                       .RETIRED_SAT(16'(SAT_SMALL))) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .next_pc(next_pc),
    .stage_done(stage_done), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .imem_req(s_imem_req), .imem_addr(s_imem_addr), .pc(s_pc), .instr(s_instr),
    .instr_valid(s_instr_valid), .retired(s_retired), .halted(s_halted),
    .misalign_err(s_misalign_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  m_pc;
  logic [31:0] m_instr;
  logic        m_valid, m_req, m_halted, m_mis;
  int unsigned m_retires;

  function automatic logic [15:0] sat16(input int unsigned n, input int unsigned ceil);
    return (n > ceil) ? 16'(ceil) : 16'(n);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ".pc"},          32'(pc),           32'(m_pc));
    chk({where, ".imem_addr"},   32'(imem_addr),    32'(m_pc));
    chk({where, ".imem_req"},    32'(imem_req),     32'(m_req));
    chk({where, ".instr"},       instr,             m_instr);
    chk({where, ".instr_valid"}, 32'(instr_valid),  32'(m_valid));
    chk({where, ".retired"},     32'(retired),      32'(sat16(m_retires, 65535)));
    chk({where, ".halted"},      32'(halted),       32'(m_halted));
    chk({where, ".misalign"},    32'(misalign_err), 32'(m_mis));
    chk({where, ".sat_retired"}, 32'(s_retired),    32'(sat16(m_retires, SAT_SMALL)));
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_instr = 32'h0; m_valid = 1'b0; m_req = 1'b0;
    m_halted = 1'b0; m_mis = 1'b0; m_retires = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    start = 1'b0; stage_done = 1'b0; imem_ack = 1'b0;
  endtask

  task automatic rand_data();
    logic [31:0] r;
    r = $urandom; imem_rdata = r;
    r = $urandom; next_pc = r[7:0];
  endtask

  // Cycle in IDLE or HALT with ack/stage_done noise; nothing may move.
  task automatic idle_noise(input string where);
    rand_data();
    imem_ack = 1'($urandom_range(0, 1));
    stage_done = 1'($urandom_range(0, 1));
    start = 1'b0;
    cyc();
    quiet_inputs();
    check_all(where);
  endtask

  task automatic do_start(input string where);
    rand_data();
    imem_ack = 1'($urandom_range(0, 1));
    stage_done = 1'($urandom_range(0, 1));
    start = 1'b1;
    cyc();
    quiet_inputs();
    m_pc = RST_PC; m_retires = 0; m_mis = 1'b0; m_halted = 1'b0;
    m_valid = 1'b0; m_req = 1'b1;
    check_all(where);
  endtask

  task automatic do_fetch(input string where, input logic [31:0] word, input int wait_n);
    for (int i = 0; i < wait_n; i++) begin
      rand_data();
      imem_ack = 1'b0;
      stage_done = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      cyc();
      quiet_inputs();
      check_all({where, ".wait"});
    end
    rand_data();
    imem_rdata = word;
    imem_ack = 1'b1;
    stage_done = 1'($urandom_range(0, 1));
    start = 1'($urandom_range(0, 1));
    cyc();
    quiet_inputs();
    m_instr = word; m_valid = 1'b1; m_req = 1'b0;
    check_all(where);
  endtask

  task automatic do_exec(input string where, input logic [7:0] npc, input int wait_n);
    for (int i = 0; i < wait_n; i++) begin
      rand_data();
      stage_done = 1'b0;
      imem_ack = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      cyc();
      quiet_inputs();
      check_all({where, ".wait"});
    end
    rand_data();
    next_pc = npc;
    stage_done = 1'b1;
    imem_ack = 1'($urandom_range(0, 1));
    start = 1'($urandom_range(0, 1));
    cyc();
    quiet_inputs();
    m_valid = 1'b0;
    m_retires++;
    if (npc[1:0] != 2'b00) begin
      m_halted = 1'b1; m_mis = 1'b1;
    end else if (m_instr == HALT_I) begin
      m_halted = 1'b1;
    end else begin
      m_pc = npc; m_req = 1'b1;
    end
    check_all(where);
  endtask

  // Asynchronous reset between clock edges, checked before the next edge.
  task automatic do_reset_async(input string where);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(where);
    stage_done = 1'b1; imem_ack = 1'b1;
    cyc();
    check_all({where, ".held"});
    @(negedge clk);
    rst_n = 1'b1;
    stage_done = 1'b1; imem_ack = 1'b1; rand_data();
    cyc();
    quiet_inputs();
    check_all({where, ".after"});
  endtask

  initial begin
    logic [31:0] word;
    logic [31:0] r;
    logic [7:0]  npc;
    int          pick;

    rst_n = 1'b0;
    quiet_inputs();
    next_pc = 8'h0;
    imem_rdata = 32'h0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle_noise("idle");

    // Basic fetch, branch, halt and restart
    do_start("start");
    do_fetch("fetch0", 32'h00500093, 2);
    do_exec("branch", 8'h10, 1);
    do_fetch("fetch_halt", HALT_I, 0);
    do_exec("halt", 8'h08, 0);
    for (int i = 0; i < 3; i++) idle_noise("halted_hold");
    do_start("restart");

    // Misalignment takes precedence over the halt instruction
    do_fetch("fetch_mis", HALT_I, 1);
    do_exec("misalign", 8'h06, 0);
    idle_noise("mis_hold");
    do_start("restart_mis");

    // pc wrap
    do_fetch("wrap_f0", NOP_I, 0);
    do_exec("wrap_to_fc", 8'hFC, 0);
    do_fetch("wrap_f1", NOP_I, 0);
    do_exec("wrap_to_00", 8'h00, 0);
    do_fetch("wrap_f2", NOP_I, 0);

    // Saturation: drive the small-ceiling instance well past its limit
    do_exec("sat_e", 8'h04, 0);
    for (int i = 0; i < int'(SAT_SMALL) + 12; i++) begin
      do_fetch("sat_f", NOP_I, 0);
      do_exec("sat_e", m_pc + 8'd4, 0);
    end

    // Reset while an instruction is held for decode
    do_fetch("pre_rst", NOP_I, 1);
    do_reset_async("rst_exec");
    idle_noise("post_rst");

    // Random programs
    for (int p = 0; p < 14; p++) begin
      do_start("r_start");
      for (int k = 0; k < 30 && !m_halted; k++) begin
        r = $urandom;
        word = ($urandom_range(0, 9) == 0) ? HALT_I : r;
        pick = int'($urandom_range(0, 19));
        r = $urandom;
        if (pick == 0) begin
          npc = r[7:0];
          if (npc[1:0] == 2'b00) npc[0] = 1'b1;
        end else if (pick < 6) begin
          npc = {r[7:2], 2'b00};
        end else begin
          npc = m_pc + 8'd4;
        end
        do_fetch("r_fetch", word, int'($urandom_range(0, 3)));
        if (p % 5 == 4 && k == 3) break;
        do_exec("r_exec", npc, int'($urandom_range(0, 3)));
      end
      if (m_halted) begin
        idle_noise("r_halt");
      end else begin
        do_reset_async("r_reset");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
PC_FETCH_SEQUENCER -- requirements
Module: pc_fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'd0, meaning the PC loaded on reset, start and restart.
REQ-002 SHALL have parameter HALT_INSTR, default 32'h00000073 (ecall), meaning the instruction whose retirement halts the sequencer.
REQ-003 SHALL have port clk, input, 1, meaning the single rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, meaning begin execution from RESET_PC; honoured only in IDLE and HALT.
REQ-006 SHALL have port next_pc, input, 8, meaning the next address from the branch/PC+4 adder; valid when stage_done=1.
REQ-007 SHALL have port stage_done, input, 1, meaning execute/writeback of the current instruction is complete.
REQ-008 SHALL have port imem_ack, input, 1, meaning instruction memory returns data this cycle.
REQ-009 SHALL have port imem_rdata, input, 32, meaning instruction word; valid when imem_ack=1.
REQ-010 SHALL have port imem_req, output, 1, meaning fetch request to instruction memory.
REQ-011 SHALL have port imem_addr, output, 8, meaning fetch byte address; always equal to pc.
REQ-012 SHALL have port pc, output, 8, meaning the current program counter, fed to the adder.
REQ-013 SHALL have port instr, output, 32, meaning the latched instruction presented to decode.
REQ-014 SHALL have port instr_valid, output, 1, meaning instr holds an instruction awaiting stage_done.
REQ-015 SHALL have port retired, output, 16, meaning count of retired instructions.
REQ-016 SHALL have port halted, output, 1, meaning the sequencer is in HALT.
REQ-017 SHALL have port misalign_err, output, 1, meaning HALT was entered because next_pc[1:0]!=2'b00.

Function
REQ-018 SHALL implement states IDLE, FETCH, EXEC, HALT, with all outputs registered.
REQ-019 SHALL, in IDLE, hold pc=RESET_PC and imem_req=0, and move to FETCH on the edge where start=1, asserting imem_req from the next cycle.
REQ-020 SHALL, in FETCH, hold imem_req=1 until imem_ack is sampled high, then on that edge latch imem_rdata into instr, set instr_valid=1, clear imem_req and enter EXEC; that is, one-cycle latency from ack to instr_valid.
REQ-021 SHALL, in EXEC, hold instr and instr_valid=1 stable until stage_done is sampled high.
REQ-022 SHALL, on an EXEC stage_done edge, clear instr_valid and increment retired, saturating at 16'hFFFF.
REQ-023 SHALL, on the same EXEC stage_done edge, enter HALT with misalign_err=1 and pc unchanged if next_pc[1:0]!=2'b00.
REQ-024 SHALL, on the same EXEC stage_done edge, otherwise enter HALT with pc unchanged if instr==HALT_INSTR.
REQ-025 SHALL, on the same EXEC stage_done edge, otherwise load pc<=next_pc, enter FETCH and assert imem_req in the next cycle.
REQ-026 SHALL treat pc arithmetic as modulo 256, so next_pc=8'h00 after pc=8'hFC is a legal wrap.
REQ-027 SHALL ignore imem_ack outside FETCH, stage_done outside EXEC, and start in FETCH/EXEC.
REQ-028 SHALL give misalignment precedence over HALT_INSTR when both apply on the same edge.
REQ-029 SHALL assert halted=1 in HALT, with pc, instr and retired frozen.
REQ-030 SHALL, on start in HALT, set pc=RESET_PC, clear retired, misalign_err, halted and instr_valid, and enter FETCH.

Reset
REQ-031 SHALL, on rst_n low (asynchronous, any state including mid-fetch or mid-EXEC), immediately force state=IDLE, pc=RESET_PC, imem_req=0, instr=0, instr_valid=0, retired=0, halted=0 and misalign_err=0.
REQ-032 SHALL leave IDLE only via start after rst_n deasserts; a pending imem_ack or stage_done is discarded.

Verification
REQ-033 Basic fetch: reset, start at cycle 1 -> imem_req=1, imem_addr=8'h00 at cycle 2; imem_ack with rdata 32'h00500093 at cycle 4 -> instr_valid=1, instr=32'h00500093 at cycle 5.
REQ-034 Branch: stage_done with next_pc=8'h10 -> retired=1, pc=8'h10, imem_req=1 next cycle.
REQ-035 Halt: instr=32'h00000073 and stage_done with next_pc=8'h08 -> halted=1, pc unchanged, no further imem_req; start -> pc=8'h00, retired=0.
REQ-036 Misalign: stage_done with next_pc=8'h06 and instr=32'h00000073 -> halted=1, misalign_err=1.
REQ-037 Wrap and saturation: pc=8'hFC, next_pc=8'h00 -> fetch at 8'h00; preload retired at 16'hFFFF via 65535 retires -> stays 16'hFFFF.
REQ-038 Reset mid-EXEC: rst_n low while instr_valid=1 -> all outputs at reset values in the same cycle; stage_done after deassert -> no change.
